axicb_slv_switch: RTL
=====================

AXICB_SLV_SWITCH -- requirements
Module: axicb_slv_switch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AXI_ADDR_W, 16, address width.
- AXI_ID_W, 8, ID width.
- AXI_DATA_W, 8, data width.
- SLVk_START_ADDR / SLVk_END_ADDR (k=0..3), k*'h1000 / k*'h1000+'h0FFF, inclusive decode range of slave k.
- WFIFO_DEPTH, 8, outstanding-write routing entries, power of 2.
- AWCH_W / WCH_W / BCH_W / ARCH_W / RCH_W, 8 each, concatenated channel widths.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- aclk, in, 1, sole clock.
- aresetn, in, 1, synchronous active-low reset.
- i_awvalid / i_awready, in / out, 1 each, AW handshake from master.
- i_awch, in, AWCH_W, AW payload.
- i_wvalid / i_wready / i_wlast, in / out / in, 1 each, W handshake and last beat.
- i_wch, in, WCH_W, W payload.
- i_bvalid / i_bready, out / in, 1 each, B handshake to master.
- i_bch, out, BCH_W, B payload.
- i_arvalid / i_arready, in / out, 1 each, AR handshake from master.
- i_arch, in, ARCH_W, AR payload.
- i_rvalid / i_rready / i_rlast, out / in / out, 1 each, R handshake and last beat.
- i_rch, out, RCH_W, R payload.
- o_awvalid, o_wvalid, o_arvalid, out, 4 each, per-slave request valids.
- o_awready, o_wready, o_arready, in, 4 each, per-slave request readies.
- o_awch / o_wch / o_wlast / o_arch, out, channel width, payloads broadcast to all slaves.
- o_bvalid / o_bready, in / out, 4 each, per-slave B handshake.
- o_bch, in, 4*BCH_W, per-slave B payloads.
- o_rvalid / o_rready / o_rlast, in / out / in, 4 each, per-slave R handshake.
- o_rch, in, 4*RCH_W, per-slave R payloads.
REQ-003 Field layout, LSB first: AWCH/ARCH = ADDR[AXI_ADDR_W], ID[AXI_ID_W], LEN[8], remainder; BCH = ID, RESP[2]; RCH = ID, RESP[2], DATA.

Function
REQ-004 AW/AR decode: slave k SHALL be selected when START_k <= ADDR <= END_k; on overlap, lowest k wins; no match = DECERR target (index 4).
REQ-005 AW to slave k SHALL be combinational: o_awvalid[k]=i_awvalid, i_awready=o_awready[k]; gated to 0 while the W FIFO is full.
REQ-006 Each AW handshake SHALL push its target index (0..4) into the W routing FIFO; W SHALL route only to the FIFO head, starting the cycle after the push (no pass-through).
REQ-007 W FIFO head pop SHALL occur on i_wvalid & i_wready & i_wlast; empty FIFO forces i_wready=0, o_wvalid=0.
REQ-008 Head=4 (DECERR) SHALL sink W beats with i_wready=1; on the wlast beat, a DECERR B (ID latched at AW accept, RESP=2'b11) becomes pending.
REQ-009 Only one unmapped AW SHALL be outstanding; further unmapped AW stall (i_awready=0) until its B handshake completes.
REQ-010 B return SHALL round-robin over 5 sources (slaves 0..3, DECERR) with the pointer advancing past the winner on each i_bvalid & i_bready; o_bready only to the winner.
REQ-011 AR routing SHALL mirror REQ-005 without FIFO gating; an unmapped AR is accepted only when the read DECERR engine is IDLE, else stalled.
REQ-012 Read DECERR FSM SHALL have states IDLE -> RESP on unmapped AR accept (latch ID, LEN); RESP emits LEN+1 beats, DATA=0, RESP=2'b11, rlast on final beat; returns to IDLE after final handshake.
REQ-013 R return SHALL round-robin over 5 sources and lock to the winner from its first beat until its rlast handshake.
REQ-014 Beat counter SHALL be 9 bits; LEN=255 yields 256 beats.
REQ-015 An AW and W-pop in the same cycle on a full FIFO SHALL still stall AW; simultaneous push and pop on a non-full FIFO keep the count unchanged.

Reset
REQ-016 With aresetn=0 sampled at a rising aclk edge: FIFO empty, both DECERR engines idle, RR pointers to slave 0, R lock cleared.
REQ-017 During and after reset, all valid and ready outputs SHALL be 0 until FIFO/arbiters permit; any in-flight burst is discarded.

Verification
REQ-018 AW addr 'h2010 ID 5 LEN 3 -> o_awvalid=4'b0100; 4 W beats reach slave 2 only; slave B ID 5 returned.
REQ-019 AW addr 'h8000 ID 7 + 2 W beats -> W sunk; i_bch ID 7, RESP=2'b11 one or more cycles after wlast.
REQ-020 AR addr 'h9000 ID 3 LEN 2 -> 3 R beats, DATA 0, RESP 2'b11, rlast on beat 3 only.
REQ-021 Slaves 1 and 3 assert R bursts together -> full slave-1 burst, then full slave-3 burst, no interleave.
REQ-022 9 AWs without W -> 9th stalls (i_awready=0) until the first wlast handshake.
REQ-023 aresetn low mid-burst for 1 cycle -> all valid outputs 0 next cycle; FIFO empty.

Source files
------------

// File: rtl/axicb_slv_switch.sv
// axicb_slv_switch: AXI slave-side switch. It routes one master port to four slaves
// by address decode and answers unmapped addresses with DECERR.
//
// Ports
//   aclk, aresetn                  clock and synchronous active-low reset
//   i_aw*/i_w*/i_b*/i_ar*/i_r*     master-facing AXI channels
//   o_aw*/o_w*/o_ar*               per-slave request valids and readies; payloads go to all slaves
//   o_b*/o_r*                      per-slave response channels; payloads are packed 4-wide
//
// Routing
//   Write data follows a FIFO of AW targets. The W beats of an AW go out from the cycle
//   after that AW is accepted. Target index 4 means an unmapped address (DECERR).
//   B and R return round-robin over 4 slaves plus the DECERR source. R stays locked to
//   one source until the rlast handshake, so bursts never interleave.
module axicb_slv_switch #(
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 8,
  parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
  parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
  parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
  parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
  parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
  parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
  parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
  parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
  parameter int WFIFO_DEPTH = 8,
  parameter int AWCH_W = 8,
  parameter int WCH_W  = 8,
  parameter int BCH_W  = 8,
  parameter int ARCH_W = 8,
  parameter int RCH_W  = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i_awvalid,
  output logic                i_awready,
  input  logic [AWCH_W-1:0]   i_awch,
  input  logic                i_wvalid,
  output logic                i_wready,
  input  logic                i_wlast,
  input  logic [WCH_W-1:0]    i_wch,
  output logic                i_bvalid,
  input  logic                i_bready,
  output logic [BCH_W-1:0]    i_bch,
  input  logic                i_arvalid,
  output logic                i_arready,
  input  logic [ARCH_W-1:0]   i_arch,
  output logic                i_rvalid,
  input  logic                i_rready,
  output logic                i_rlast,
  output logic [RCH_W-1:0]    i_rch,
  output logic [3:0]          o_awvalid,
  input  logic [3:0]          o_awready,
  output logic [AWCH_W-1:0]   o_awch,
  output logic [3:0]          o_wvalid,
  input  logic [3:0]          o_wready,
  output logic                o_wlast,
  output logic [WCH_W-1:0]    o_wch,
  input  logic [3:0]          o_bvalid,
  output logic [3:0]          o_bready,
  input  logic [4*BCH_W-1:0]  o_bch,
  output logic [3:0]          o_arvalid,
  input  logic [3:0]          o_arready,
  output logic [ARCH_W-1:0]   o_arch,
  input  logic [3:0]          o_rvalid,
  output logic [3:0]          o_rready,
  input  logic [3:0]          o_rlast,
  input  logic [4*RCH_W-1:0]  o_rch
);

  localparam int PW    = $clog2(WFIFO_DEPTH);
  localparam int AWF_W = AXI_ADDR_W + AXI_ID_W;      // AW fields used here: ADDR, ID
  localparam int ARF_W = AXI_ADDR_W + AXI_ID_W + 8;  // AR fields used here: ADDR, ID, LEN
  localparam logic [2:0] DECERR = 3'd4;
  localparam logic [AXI_ADDR_W-1:0] SLV_START [4] =
    '{SLV0_START_ADDR, SLV1_START_ADDR, SLV2_START_ADDR, SLV3_START_ADDR};
  localparam logic [AXI_ADDR_W-1:0] SLV_END [4] =
    '{SLV0_END_ADDR, SLV1_END_ADDR, SLV2_END_ADDR, SLV3_END_ADDR};

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // The unsigned offset test covers start <= addr <= end in a single compare.
  // Slaves are scanned from highest to lowest, so the lowest matching k wins.
  function automatic logic [2:0] decode(input logic [AXI_ADDR_W-1:0] addr);
    decode = DECERR;
    for (int k = 3; k >= 0; k--)
      if ((addr - SLV_START[k]) <= (SLV_END[k] - SLV_START[k])) decode = 3'(k);
  endfunction

  // Return the first requester at or after ptr. The scan wraps over the 5 sources.
  function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] s;
    rr_pick = ptr;
    for (int i = 4; i >= 0; i--) begin
      s = {1'b0, ptr} + 4'(i);
      if (s >= 4'd5) s = s - 4'd5;
      if (req[s[2:0]]) rr_pick = s[2:0];
    end
  endfunction

  function automatic logic [2:0] next_src(input logic [2:0] sel);
    return (sel == DECERR) ? 3'd0 : sel + 3'd1;
  endfunction

  // Channel field extraction. The payload is zero-extended if it is narrower than the fields.
  logic [AWF_W-1:0] aw_f;
  logic [ARF_W-1:0] ar_f;
  logic [2:0]       aw_tgt, ar_tgt;
  assign aw_f   = AWF_W'(i_awch);
  assign ar_f   = ARF_W'(i_arch);
  assign aw_tgt = decode(aw_f[AXI_ADDR_W-1:0]);
  assign ar_tgt = decode(ar_f[AXI_ADDR_W-1:0]);

  // W routing FIFO
  logic [2:0]    wfifo [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   w_count;
  logic          wfifo_full, wfifo_empty, aw_ok, aw_push, w_pop;
  logic [2:0]    w_head;
  logic          wdec_busy, wb_pending;
  logic [AXI_ID_W-1:0] wb_id;

  assign wfifo_full  = (w_count == (PW+1)'(WFIFO_DEPTH));
  assign wfifo_empty = (w_count == '0);
  assign w_head      = wfifo[rd_ptr];
  assign aw_ok       = aresetn & ~wfifo_full & ~((aw_tgt == DECERR) & wdec_busy);
  assign i_awready   = aw_ok & ((aw_tgt == DECERR) | o_awready[aw_tgt[1:0]]);
  assign aw_push     = i_awvalid & i_awready;
  assign i_wready    = aresetn & ~wfifo_empty & ((w_head == DECERR) | o_wready[w_head[1:0]]);
  assign w_pop       = i_wvalid & i_wready & i_wlast;

  assign o_awch  = i_awch;
  assign o_arch  = i_arch;
  assign o_wch   = i_wch;
  assign o_wlast = i_wlast;

  // B return
  logic [4:0] b_req;
  logic [2:0] b_ptr, b_sel;
  logic       b_hs;
  logic [BCH_W-1:0] b_slv [4];
  assign b_req    = {wb_pending, o_bvalid};
  assign b_sel    = rr_pick(b_req, b_ptr);
  assign i_bvalid = aresetn & (|b_req);
  assign i_bch    = (b_sel == DECERR) ? BCH_W'({2'b11, wb_id}) : b_slv[b_sel[1:0]];
  assign b_hs     = i_bvalid & i_bready;

  // Read DECERR engine and R return
  rd_state_t rd_state, rd_next;
  logic [AXI_ID_W-1:0] rd_id;
  logic [7:0]          rd_len;
  logic [8:0]          rd_cnt;
  logic                rdec_last, rdec_hs, ar_dec_hs;
  logic [4:0]          r_req;
  logic [2:0]          r_ptr, r_sel, r_lock_idx;
  logic                r_locked, r_any, r_hs;
  logic [RCH_W-1:0]    r_slv [4];

  assign i_arready = aresetn & ((ar_tgt == DECERR) ? (rd_state == RD_IDLE) : o_arready[ar_tgt[1:0]]);
  assign ar_dec_hs = i_arvalid & i_arready & (ar_tgt == DECERR);
  assign rdec_last = (rd_cnt == {1'b0, rd_len});
  assign r_req     = {rd_state == RD_RESP, o_rvalid};
  assign r_sel     = r_locked ? r_lock_idx : rr_pick(r_req, r_ptr);
  assign r_any     = r_locked ? r_req[r_lock_idx] : (|r_req);
  assign i_rvalid  = aresetn & r_any;
  assign i_rlast   = (r_sel == DECERR) ? rdec_last : o_rlast[r_sel[1:0]];
  assign i_rch     = (r_sel == DECERR) ? RCH_W'({{AXI_DATA_W{1'b0}}, 2'b11, rd_id})
                                       : r_slv[r_sel[1:0]];
  assign r_hs      = i_rvalid & i_rready;
  assign rdec_hs   = r_hs & (r_sel == DECERR);

  // NOTE: every combinational output gets a default before the loop, so none can hold a value (no latch).
  always_comb begin
    o_awvalid = '0;
    o_wvalid  = '0;
    o_arvalid = '0;
    o_bready  = '0;
    o_rready  = '0;
    for (int k = 0; k < 4; k++) begin
      b_slv[k]     = o_bch[k*BCH_W +: BCH_W];
      r_slv[k]     = o_rch[k*RCH_W +: RCH_W];
      o_awvalid[k] = i_awvalid & aw_ok & (aw_tgt == 3'(k));
      o_wvalid[k]  = aresetn & i_wvalid & ~wfifo_empty & (w_head == 3'(k));
      o_arvalid[k] = aresetn & i_arvalid & (ar_tgt == 3'(k));
      o_bready[k]  = i_bvalid & i_bready & (b_sel == 3'(k));
      o_rready[k]  = i_rvalid & i_rready & (r_sel == 3'(k));
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_dec_hs)             rd_next = RD_RESP;
      RD_RESP: if (rdec_hs && rdec_last)  rd_next = RD_IDLE;
      default:                            rd_next = RD_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset. The count and pointers are reset, so stale entries are never read.
  always_ff @(posedge aclk) begin
    if (aw_push) wfifo[wr_ptr] <= aw_tgt;
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers then update together at the edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      w_count    <= '0;
      wdec_busy  <= 1'b0;
      wb_pending <= 1'b0;
      wb_id      <= '0;
      b_ptr      <= '0;
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      rd_state   <= RD_IDLE;
      rd_id      <= '0;
      rd_len     <= '0;
      rd_cnt     <= '0;
    end else begin
      rd_state <= rd_next;
      if (aw_push) wr_ptr <= wr_ptr + PW'(1);
      if (w_pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({aw_push, w_pop})
        2'b10:   w_count <= w_count + (PW+1)'(1);
        2'b01:   w_count <= w_count - (PW+1)'(1);
        default: ;
      endcase
      if (aw_push && aw_tgt == DECERR) begin
        wdec_busy <= 1'b1;
        wb_id     <= aw_f[AXI_ADDR_W +: AXI_ID_W];
      end
      if (w_pop && w_head == DECERR) wb_pending <= 1'b1;
      if (b_hs) begin
        b_ptr <= next_src(b_sel);
        if (b_sel == DECERR) begin
          wb_pending <= 1'b0;
          wdec_busy  <= 1'b0;
        end
      end
      if (ar_dec_hs) begin
        rd_id  <= ar_f[AXI_ADDR_W +: AXI_ID_W];
        rd_len <= ar_f[AXI_ADDR_W+AXI_ID_W +: 8];
        rd_cnt <= '0;
      end else if (rdec_hs) begin
        rd_cnt <= rd_cnt + 9'd1;
      end
      if (r_hs) begin
        if (i_rlast) begin
          r_locked <= 1'b0;
          r_ptr    <= next_src(r_sel);
        end else begin
          r_locked   <= 1'b1;
          r_lock_idx <= r_sel;
        end
      end
    end
  end

endmodule
